// File: rtl/bus_pkg.sv
// Shared definitions for the 74245 bank sequencer.
//   DIR_A2B / DIR_B2A : dir pin encoding, identical to the hct74245 DIR input.
//   state_e           : sequencer states.
package bus_pkg;

  localparam logic DIR_A2B = 1'b1;
  localparam logic DIR_B2A = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TURN  = 2'd1,
    DRIVE = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/bus_xcvr_seq_cycle_timer.sv
// Loadable down-counter with a zero flag, used to time both the dead window
// after a dir change and the settle window while a transceiver is enabled.
// Loading N makes zero_o rise N cycles after the load edge.
//   clk_i      : clock
//   reset_i    : synchronous active-high reset (count cleared)
//   load_i     : load load_val_i at the next edge
//   load_val_i : value to load
//   zero_o     : count is zero
module cycle_timer #(
  parameter int unsigned CNT_W = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/bus_xcvr_seq.sv
// Break-before-make sequencer for a bank of hct74245 transceivers sharing one
// 8-bit A-side bus. Accepts single-byte read/write requests on valid/ready,
// turns the selected transceiver's dir with all enables off, enables it for a
// fixed settle window, and captures read data on the edge leaving that window.
//   clk, reset              : clock, synchronous active-high reset
//   req_valid/req_ready     : request handshake (ready only in IDLE, not in reset)
//   req_dir/req_sel/req_wdata : 1 = write A->B, transceiver index, write byte
//   xcvr_dir/xcvr_nOE       : per-transceiver dir and active-low enable pins
//   a_out/a_oe              : A-side drive value and tristate enable
//   a_in                    : A-side sampled value
//   rd_data                 : last captured read byte
//   done/err                : completion pulse, err = select out of range
module bus_xcvr_seq
  import bus_pkg::*;
#(
  parameter int unsigned NUM_XCVR      = 4,
  parameter int unsigned SEL_W         = (NUM_XCVR > 1) ? $clog2(NUM_XCVR) : 1,
  parameter int unsigned DEAD_CYCLES   = 1,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_dir,
  input  logic [SEL_W-1:0]    req_sel,
  input  logic [7:0]          req_wdata,
  output logic [NUM_XCVR-1:0] xcvr_dir,
  output logic [NUM_XCVR-1:0] xcvr_nOE,
  output logic [7:0]          a_out,
  output logic                a_oe,
  input  logic [7:0]          a_in,
  output logic [7:0]          rd_data,
  output logic                done,
  output logic                err
);

  localparam int unsigned MAX_WIN = (DEAD_CYCLES > SETTLE_CYCLES) ? DEAD_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CNT_W   = (MAX_WIN > 1) ? $clog2(MAX_WIN) : 1;
  localparam logic [CNT_W-1:0] DEAD_LOAD   = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_e              state_q;
  logic [NUM_XCVR-1:0] sel_oh_q;
  logic                dir_q;
  logic [7:0]          wdata_q;
  logic [NUM_XCVR-1:0] xcvr_dir_q;
  logic [NUM_XCVR-1:0] xcvr_noe_q;
  logic [7:0]          a_out_q;
  logic                a_oe_q;
  logic [7:0]          rd_data_q;
  logic                done_q;
  logic                err_q;

  logic                ready_w;
  logic                accept;
  logic                in_range;
  logic [NUM_XCVR-1:0] sel_mask;
  logic                need_turn;
  logic                tmr_load;
  logic [CNT_W-1:0]    tmr_val;
  logic                tmr_zero;

  assign ready_w  = (state_q == IDLE) && !reset;
  assign accept   = req_valid && ready_w;
  assign in_range = (32'(req_sel) < NUM_XCVR);

  // One-hot select built by comparison so an out-of-range index never
  // addresses a nonexistent pin; it simply yields an all-zero mask.
  always_comb begin
    sel_mask = '0;
    for (int unsigned i = 0; i < NUM_XCVR; i++) begin
      sel_mask[i] = (req_sel == SEL_W'(i));
    end
  end

  assign need_turn = |((xcvr_dir_q ^ {NUM_XCVR{req_dir}}) & sel_mask);

  // The timer is loaded on the edge entering TURN or DRIVE so its zero flag
  // marks the last cycle of that window.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (accept && in_range) begin
      tmr_load = 1'b1;
      tmr_val  = need_turn ? DEAD_LOAD : SETTLE_LOAD;
    end else if ((state_q == TURN) && tmr_zero) begin
      tmr_load = 1'b1;
      tmr_val  = SETTLE_LOAD;
    end
  end

  cycle_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk_i      (clk),
    .reset_i    (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      sel_oh_q   <= '0;
      dir_q      <= DIR_A2B;
      wdata_q    <= '0;
      xcvr_dir_q <= '1;
      xcvr_noe_q <= '1;
      a_out_q    <= '0;
      a_oe_q     <= 1'b0;
      rd_data_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            sel_oh_q <= sel_mask;
            dir_q    <= req_dir;
            wdata_q  <= req_wdata;
            if (!in_range) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else if (need_turn) begin
              // Only the selected dir bit moves; every enable stays high.
              state_q    <= TURN;
              xcvr_dir_q <= (xcvr_dir_q & ~sel_mask) | (sel_mask & {NUM_XCVR{req_dir}});
            end else begin
              state_q    <= DRIVE;
              xcvr_noe_q <= ~sel_mask;
              if (req_dir == DIR_A2B) begin
                a_oe_q  <= 1'b1;
                a_out_q <= req_wdata;
              end
            end
          end
        end
        TURN: begin
          if (tmr_zero) begin
            state_q    <= DRIVE;
            xcvr_noe_q <= ~sel_oh_q;
            if (dir_q == DIR_A2B) begin
              a_oe_q  <= 1'b1;
              a_out_q <= wdata_q;
            end
          end
        end
        DRIVE: begin
          if (tmr_zero) begin
            state_q    <= DONE;
            xcvr_noe_q <= '1;
            a_oe_q     <= 1'b0;
            done_q     <= 1'b1;
            if (dir_q == DIR_B2A) begin
              rd_data_q <= a_in;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = ready_w;
  assign xcvr_dir  = xcvr_dir_q;
  assign xcvr_nOE  = xcvr_noe_q;
  assign a_out     = a_out_q;
  assign a_oe      = a_oe_q;
  assign rd_data   = rd_data_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bus_xcvr_seq.sv
// Scoreboard bench for bus_xcvr_seq: the stimulus process pushes a
// hand-computed expectation per request; a monitor measures each transfer
// (latency, enable pattern, dead cycles, A/B side data) and compares at done.
module tb_bus_xcvr_seq;

  localparam int unsigned N = 4;
  localparam int unsigned SW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_dir = 1'b0;
  logic [SW-1:0] req_sel = '0;
  logic [7:0]    req_wdata = '0;
  logic [N-1:0]  xcvr_dir;
  logic [N-1:0]  xcvr_nOE;
  logic [7:0]    a_out;
  logic          a_oe;
  logic [7:0]    a_in;
  logic [7:0]    rd_data;
  logic          done;
  logic          err;

  logic [7:0]    b_drv = 8'h00;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int         sel;
    logic [7:0] wdata;
    int         lat;
    int         idle_cyc;
    int         noe_cyc;
    logic [3:0] exp_noe;
    logic       exp_aoe;
    logic [3:0] exp_dir;
    logic [7:0] exp_rd;
    logic [7:0] exp_aout;
    logic       exp_err;
  } exp_t;

  exp_t sb_q[$];

  bus_xcvr_seq #(
    .NUM_XCVR      (N),
    .SEL_W         (SW),
    .DEAD_CYCLES   (1),
    .SETTLE_CYCLES (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_dir   (req_dir),
    .req_sel   (req_sel),
    .req_wdata (req_wdata),
    .xcvr_dir  (xcvr_dir),
    .xcvr_nOE  (xcvr_nOE),
    .a_out     (a_out),
    .a_oe      (a_oe),
    .a_in      (a_in),
    .rd_data   (rd_data),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // B side of an enabled read transceiver drives b_drv through to the A side.
  always_comb begin
    a_in = 8'h00;
    for (int i = 0; i < N; i++) begin
      if (!xcvr_nOE[i] && !xcvr_dir[i]) a_in = b_drv;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: tracks the transfer in flight and compares on done.
  logic in_txn = 1'b0;
  logic has_exp = 1'b0;
  exp_t cur;
  int acc_cyc, noe_cnt, idle_cnt, other_cnt, data_bad;

  always @(negedge clk) begin
    if (reset) begin
      in_txn = 1'b0;
    end else begin
      if (done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("latency",     32'(cyc - acc_cyc), 32'(e.lat));
          check("err",         32'(err),           32'(e.exp_err));
          check("noe_cycles",  32'(noe_cnt),       32'(e.noe_cyc));
          check("dead_cycles", 32'(idle_cnt),      32'(e.idle_cyc));
          check("other_noe",   32'(other_cnt),     32'd0);
          check("drive_data",  32'(data_bad),      32'd0);
          check("dir_at_done", 32'(xcvr_dir),      32'(e.exp_dir));
          check("rd_data",     32'(rd_data),       32'(e.exp_rd));
          check("a_out",       32'(a_out),         32'(e.exp_aout));
          check("noe_at_done", 32'(xcvr_nOE),      32'hF);
          check("aoe_at_done", 32'(a_oe),          32'd0);
        end
        in_txn = 1'b0;
      end else if (in_txn && has_exp) begin
        if (xcvr_nOE == 4'hF) begin
          idle_cnt++;
          if (a_oe) data_bad++;
        end else if (xcvr_nOE == cur.exp_noe) begin
          noe_cnt++;
          if (a_oe !== cur.exp_aoe) data_bad++;
          else if (cur.exp_aoe) begin
            // B side of the selected 74245 while it passes A to B
            logic [7:0] b_val;
            b_val = (xcvr_dir[cur.sel] && a_oe) ? a_out : 8'h00;
            if (b_val !== cur.wdata) data_bad++;
          end
        end else begin
          other_cnt++;
        end
      end
      if (req_valid && req_ready) begin
        acc_cyc   = cyc + 1;
        in_txn    = 1'b1;
        has_exp   = (sb_q.size() > 0);
        if (has_exp) cur = sb_q[0];
        noe_cnt   = 0;
        idle_cnt  = 0;
        other_cnt = 0;
        data_bad  = 0;
      end
    end
  end

  // Pin-safety invariants, evaluated every cycle outside reset.
  logic [N-1:0] prev_noe, prev2_noe, prev_dir;
  int hist = 0;

  always @(negedge clk) begin
    if (reset) begin
      hist = 0;
    end else begin
      if (hist >= 2) begin
        logic ok;
        logic [N-1:0] chg;
        ok  = ($countones(~xcvr_nOE) <= 1);
        if (a_oe && ((~xcvr_nOE == '0) || ((~xcvr_nOE & ~xcvr_dir) != '0))) ok = 1'b0;
        chg = xcvr_dir ^ prev_dir;
        if ((chg & ~(xcvr_nOE & prev_noe & prev2_noe)) != '0) ok = 1'b0;
        n_checks++;
        if (!ok) begin
          n_fail++;
          $display("FAIL invariant: nOE=%b dir=%b a_oe=%b prev_nOE=%b prev2_nOE=%b prev_dir=%b (t=%0t)",
                   xcvr_nOE, xcvr_dir, a_oe, prev_noe, prev2_noe, prev_dir, $time);
        end
      end
      prev2_noe = prev_noe;
      prev_noe  = xcvr_nOE;
      prev_dir  = xcvr_dir;
      hist++;
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (req_ready) return;
    end
    check("ready_timeout", 32'(req_ready), 32'd1);
  endtask

  // Issue one request; returns 1ns after the accept edge.
  task automatic issue(input logic push, input int sel, input logic dir, input logic [7:0] wdata,
                       input logic [7:0] bdrv, input int lat, input int idle, input logic [3:0] noe,
                       input logic [3:0] edir, input logic [7:0] erd, input logic [7:0] eaout,
                       input logic eerr);
    exp_t e;
    wait_ready();
    e.sel = sel;       e.wdata = wdata;   e.lat = lat;       e.idle_cyc = idle;
    e.noe_cyc = eerr ? 0 : 2;             e.exp_noe = noe;   e.exp_aoe = dir & ~eerr;
    e.exp_dir = edir;  e.exp_rd = erd;    e.exp_aout = eaout; e.exp_err = eerr;
    if (push) sb_q.push_back(e);
    b_drv     = bdrv;
    req_sel   = SW'(sel);
    req_dir   = dir;
    req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_noe",   32'(xcvr_nOE),  32'hF);
    check("rst_dir",   32'(xcvr_dir),  32'hF);
    check("rst_aoe",   32'(a_oe),      32'd0);
    check("rst_aout",  32'(a_out),     32'h00);
    check("rst_rd",    32'(rd_data),   32'h00);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_done",  32'(done),      32'd0);

    //      push sel dir wdata  bdrv   lat idle noe      dir      rd     aout   err
    issue(1, 2,  1, 8'hA5, 8'h00, 2,  0,  4'b1011, 4'b1111, 8'h00, 8'hA5, 0);
    issue(1, 1,  0, 8'h00, 8'h3C, 3,  1,  4'b1101, 4'b1101, 8'h3C, 8'hA5, 0);
    issue(1, 1,  1, 8'h5A, 8'h00, 3,  1,  4'b1101, 4'b1111, 8'h3C, 8'h5A, 0);
    issue(1, 3,  0, 8'h00, 8'hC3, 3,  1,  4'b0111, 4'b0111, 8'hC3, 8'h5A, 0);
    issue(1, 3,  0, 8'h00, 8'h96, 2,  0,  4'b0111, 4'b0111, 8'h96, 8'h5A, 0);
    issue(1, 5,  0, 8'hFF, 8'h00, 0,  0,  4'b1111, 4'b0111, 8'h96, 8'h5A, 1);

    // Abort a write in its second DRIVE cycle; no done may follow.
    issue(0, 0,  1, 8'h77, 8'h00, 0,  0,  4'b1110, 4'b0111, 8'h00, 8'h00, 0);
    @(posedge clk);
    #1;
    check("abort_drive_noe", 32'(xcvr_nOE), 32'b1110);
    check("abort_drive_aout", 32'(a_out),   32'h77);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_noe",  32'(xcvr_nOE), 32'hF);
    check("abort_aoe",  32'(a_oe),     32'd0);
    check("abort_done", 32'(done),     32'd0);
    check("abort_dir",  32'(xcvr_dir), 32'hF);
    check("abort_rd",   32'(rd_data),  32'h00);
    reset = 1'b0;
    #1;
    check("abort_ready", 32'(req_ready), 32'd1);

    issue(1, 2,  0, 8'h00, 8'hE1, 3,  1,  4'b1011, 4'b1011, 8'hE1, 8'h00, 0);

    for (int i = 0; i < 100; i++) begin
      if (sb_q.size() == 0) break;
      @(posedge clk);
    end
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
